ahb3lite_bus_arbiter: RTL
=========================

// Module: ahb3lite_bus_arbiter
// PURPOSE
//  Grants ownership of one shared AHB3-Lite bus to one of N masters. Round-robin fairness; HMASTLOCK honoured.
//  Fixed-length bursts are never split. Drives the address-phase and data-phase select indices for the
//  master-to-bus muxes. Sits in front of the interconnect slave port when several masters share a bus.
// PARAMETERS
//  MASTERS        2  number of requesting masters (2..16)
//  DEFAULT_MASTER 0  index parked on the bus when no request is pending
// PORTS
//  HCLK        in   1             bus clock
//  HRESETn     in   1             asynchronous active-low reset
//  req         in   MASTERS       per-master bus request, level-sensitive
//  bus_HTRANS  in   2             HTRANS of current address-phase owner (post-mux)
//  bus_HBURST  in   3             HBURST of current owner
//  bus_HMASTLOCK in 1             HMASTLOCK of current owner
//  HREADY      in   1             bus HREADY (transfer accepted / data phase done)
//  HRESP       in   1             bus HRESP (1=ERROR)
//  gnt         out  MASTERS       one-hot grant, registered
//  addr_owner  out  $clog2(MASTERS) index muxing HADDR/HTRANS/control, registered
//  data_owner  out  $clog2(MASTERS) index muxing HWDATA and steering HRDATA/HREADY/HRESP back
// BEHAVIOUR
//  Reset: gnt=1<<DEFAULT_MASTER, addr_owner=data_owner=DEFAULT_MASTER, beat_cnt=0, state=PARK, rr_ptr=DEFAULT_MASTER.
//  All state changes only on HCLK rising edge with HREADY=1 (stall freezes everything); reset acts immediately.
//  data_owner <= addr_owner whenever HREADY=1 (one-cycle pipeline, tracks address->data phase).
//  FSM:
//   PARK   : no owner requesting; the parked master must drive IDLE. Any req -> pick winner, gnt next cycle, ->OWNED.
//   OWNED  : owner holds bus. Accepted NONSEQ with fixed burst (WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16)
//            loads beat_cnt=len-1, ->BURST. Accepted NONSEQ SINGLE or INCR stays OWNED.
//   BURST  : beat_cnt decrements on each accepted SEQ. BUSY/IDLE do not decrement.
//            beat_cnt==1 and SEQ accepted -> OWNED with release_ok for that cycle.
//  release_ok (may re-arbitrate this edge) when bus_HMASTLOCK=0, HREADY=1, and one of:
//   - bus_HTRANS==IDLE in OWNED;
//   - req[owner]==0;
//   - accepted SINGLE NONSEQ;
//   - last beat of fixed burst accepted;
//   - HRESP=1 (ERROR second cycle); the ERROR also clears beat_cnt and forces OWNED.
//   Undefined-length INCR is released only via IDLE or req drop.
//  Locked: while bus_HMASTLOCK=1 the owner is never changed regardless of other requests.
//  Arbitration: round-robin starting at rr_ptr+1 mod MASTERS; winner -> gnt/addr_owner next edge;
//   rr_ptr <= winner. If owner still requests and no other master does, owner keeps bus (no bubble).
//   If no req: grant DEFAULT_MASTER, ->PARK.
//  Latency: req rise with bus free at edge n -> gnt valid after edge n+1; owner may issue NONSEQ that cycle.
//  Simultaneous: multiple reqs on same edge -> RR order only. A req drop of a non-owner is ignored.
//   A req drop of the owner mid fixed burst is ignored until burst end, unless HRESP=1.
//  gnt is always exactly one-hot; addr_owner == index of gnt.
// STRUCTURE
//  ahb3lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_SINGLE..INCR16 localparams,
//   function burst_len(HBURST)->beats.
//  Sub-module ahb3lite_rr_picker: combinational round-robin picker
//   (req, rr_ptr -> one-hot winner, index, any_req).
//  Top: FSM, beat counter (5 bit), rr_ptr, owner/data_owner registers.
// TESTING
//  1 Reset with req=0, MASTERS=3 -> gnt=3'b001, addr_owner=data_owner=0, state PARK.
//  2 req=3'b110 same edge, bus free -> gnt=010 next edge. M1 IDLE -> gnt=100. M2 IDLE and req=110 -> gnt=010.
//  3 M0 INCR8 owned, req[1] rises after beat 2 -> gnt stays 001 through 8 accepted beats (HREADY gaps, BUSY
//    inserted), switches to 010 on edge accepting beat 8.
//  4 M0 HMASTLOCK=1 across two SINGLEs with IDLE between, req[1]=1 -> no switch until HMASTLOCK=0 with IDLE.
//  5 HREADY=0 for 3 cycles on a switch edge -> gnt, addr_owner, data_owner frozen.
//    data_owner follows addr_owner one accepted cycle later.
//  6 HRESP=1 on beat 3 of M1 WRAP4, req[0]=1 -> gnt=001 next HREADY edge, beat_cnt=0.
//    HRESETn low mid-burst -> immediate reset values.

Source files
------------

// File: rtl/ahb3lite_bus_arbiter_pkg.sv
// ahb3lite_pkg
//   Shared AHB3-Lite encodings and helpers for the bus arbiter slice.
//   - HTRANS_* / HBURST_* : transfer-type and burst-type encodings
//   - arb_state_e         : arbiter FSM states
//   - burst_len()         : beats in a fixed-length burst; 1 for SINGLE and
//                           undefined-length INCR
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ARB_PARK  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb3lite_bus_arbiter_if.sv
// ahb3lite_bus_arbiter_if
//   Bundles the request/bus-status inputs and the grant/mux-select outputs
//   of the shared-bus arbiter.
//   - slave  : arbiter side (consumes req and bus status, drives gnt/owners)
//   - master : requester/bus side (drives req and bus status, sees gnt/owners)
//   Signals: req[MASTERS], bus_HTRANS[2], bus_HBURST[3], bus_HMASTLOCK,
//            HREADY, HRESP, gnt[MASTERS], addr_owner, data_owner
interface ahb3lite_bus_arbiter_if #(
    parameter int MASTERS = 2
);
    localparam int IW = $clog2(MASTERS);

    logic [MASTERS-1:0] req;
    logic [1:0]         bus_HTRANS;
    logic [2:0]         bus_HBURST;
    logic               bus_HMASTLOCK;
    logic               HREADY;
    logic               HRESP;
    logic [MASTERS-1:0] gnt;
    logic [IW-1:0]      addr_owner;
    logic [IW-1:0]      data_owner;

    modport slave (
        input  req, bus_HTRANS, bus_HBURST, bus_HMASTLOCK, HREADY, HRESP,
        output gnt, addr_owner, data_owner
    );

    modport master (
        output req, bus_HTRANS, bus_HBURST, bus_HMASTLOCK, HREADY, HRESP,
        input  gnt, addr_owner, data_owner
    );

endinterface

// File: rtl/ahb3lite_bus_arbiter_rr_picker.sv
// ahb3lite_rr_picker
//   Combinational round-robin picker. Searches req starting at rr_ptr+1 and
//   wrapping, so rr_ptr itself (the last winner) is considered last.
//   Ports: req[MASTERS], rr_ptr -> win_oh[MASTERS] (one-hot, zero if no req),
//          win_idx, any_req
module ahb3lite_rr_picker #(
    parameter int MASTERS = 2
) (
    input  logic [MASTERS-1:0]         req,
    input  logic [$clog2(MASTERS)-1:0] rr_ptr,
    output logic [MASTERS-1:0]         win_oh,
    output logic [$clog2(MASTERS)-1:0] win_idx,
    output logic                       any_req
);
    localparam int IW = $clog2(MASTERS);

    int   cand;
    logic found;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        any_req = |req;
        for (int i = 1; i <= MASTERS; i++) begin
            cand = (int'(rr_ptr) + i) % MASTERS;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = IW'(cand);
            end
        end
        win_oh = any_req ? (MASTERS'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/ahb3lite_bus_arbiter.sv
// ahb3lite_bus_arbiter
//   Round-robin arbiter for one shared AHB3-Lite bus. Keeps fixed-length
//   bursts intact, never moves the bus while HMASTLOCK is set, parks on
//   DEFAULT_MASTER when nobody requests, and produces the address-phase and
//   data-phase mux selects.
//   Ports: HCLK, HRESETn (async, active-low)
//          bus.slave : req, bus_HTRANS, bus_HBURST, bus_HMASTLOCK, HREADY,
//                      HRESP in; gnt, addr_owner, data_owner out
//   Every register advances only on HREADY=1 edges.
module ahb3lite_bus_arbiter
    import ahb3lite_pkg::*;
#(
    parameter int MASTERS        = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb3lite_bus_arbiter_if.slave bus
);
    localparam int                 IW     = $clog2(MASTERS);
    localparam logic [IW-1:0]      DEF_IX = IW'(DEFAULT_MASTER);
    localparam logic [MASTERS-1:0] DEF_OH = MASTERS'(1) << DEFAULT_MASTER;

    arb_state_e         state_q, state_d;
    logic [4:0]         beat_q, beat_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      data_owner_q;
    logic [MASTERS-1:0] gnt_q, gnt_d;

    logic [MASTERS-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               any_req;
    logic               rel;
    logic               is_idle, is_nonseq, is_seq, fixed_burst;
    logic [4:0]         blen;

    ahb3lite_rr_picker #(.MASTERS(MASTERS)) u_picker (
        .req     (bus.req),
        .rr_ptr  (rr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    assign is_idle     = (bus.bus_HTRANS == HTRANS_IDLE);
    assign is_nonseq   = (bus.bus_HTRANS == HTRANS_NONSEQ);
    assign is_seq      = (bus.bus_HTRANS == HTRANS_SEQ);
    assign blen        = burst_len(bus.bus_HBURST);
    assign fixed_burst = (blen > 5'd1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        rel     = 1'b0;

        unique case (state_q)
            ARB_PARK: rel = 1'b1;
            ARB_OWNED: begin
                if (is_nonseq && fixed_burst) begin
                    beat_d  = blen - 5'd1;
                    state_d = ARB_BURST;
                end
                // Undefined-length INCR only frees the bus via IDLE or req drop.
                rel = is_idle || !bus.req[owner_q] ||
                      (is_nonseq && (bus.bus_HBURST == HBURST_SINGLE));
            end
            ARB_BURST: begin
                // BUSY/IDLE inside a burst neither count nor release; the
                // owner's req is ignored until the last beat.
                if (is_seq) begin
                    if (beat_q == 5'd1) begin
                        beat_d  = '0;
                        state_d = ARB_OWNED;
                        rel     = 1'b1;
                    end else begin
                        beat_d = beat_q - 5'd1;
                    end
                end
            end
            default: state_d = ARB_PARK;
        endcase

        // Second ERROR cycle aborts any burst; the bus may move on.
        if (bus.HRESP && (state_q != ARB_PARK)) begin
            beat_d  = '0;
            state_d = ARB_OWNED;
            rel     = 1'b1;
        end

        if (rel && !bus.bus_HMASTLOCK) begin
            // A released owner never carries burst state to the next owner.
            beat_d = '0;
            if (any_req) begin
                owner_d = win_idx;
                gnt_d   = win_oh;
                rr_d    = win_idx;
                state_d = ARB_OWNED;
            end else begin
                owner_d = DEF_IX;
                gnt_d   = DEF_OH;
                state_d = ARB_PARK;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ARB_PARK;
            beat_q       <= '0;
            rr_q         <= DEF_IX;
            owner_q      <= DEF_IX;
            data_owner_q <= DEF_IX;
            gnt_q        <= DEF_OH;
        end else if (bus.HREADY) begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            data_owner_q <= owner_q;
            gnt_q        <= gnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.addr_owner = owner_q;
    assign bus.data_owner = data_owner_q;

endmodule
